tl_ul_link_buffer: RTL
======================

# tl_ul_link_buffer

Registered TileLink-UL buffer stage for the core's 26-bit peripheral port. It sits directly upstream of the TL link monitor, and its A-out and D-out ports are the signals that monitor observes. It decouples the master and slave timing with a DEPTH-entry FIFO per channel. It also caps outstanding requests at MAX_INFLIGHT and flags D responses that arrive with nothing outstanding.

## Interface
- DEPTH, 2, entries per channel FIFO (≥1).
- MAX_INFLIGHT, 4, maximum A requests issued downstream without a D response (1..7).
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- a_in_valid / a_in_ready  input / output  1 / 1  upstream A handshake.
- a_in_opcode input 3, a_in_param input 3, a_in_size input 2, a_in_source input 1, a_in_address input 26, a_in_mask input 4, a_in_data input 32, a_in_corrupt input 1: upstream A payload.
- a_out_valid / a_out_ready  output / input  1 / 1  downstream A handshake.
- a_out_opcode, a_out_param, a_out_size, a_out_source, a_out_address, a_out_mask, a_out_data, a_out_corrupt: outputs, widths as a_in_*.
- d_in_valid / d_in_ready  input / output  1 / 1  downstream D handshake.
- d_in_opcode input 3, d_in_param input 2, d_in_size input 2, d_in_source input 1, d_in_sink input 1, d_in_denied input 1, d_in_data input 32, d_in_corrupt input 1: D payload from the slave.
- d_out_valid / d_out_ready  output / input  1 / 1  upstream D handshake.
- d_out_*: outputs, widths as d_in_*.
- inflight  output  3  current outstanding-request count.
- protocol_err  output  1  sticky error flag.

## Operation
- A "fire" is valid && ready in the same cycle.
- Each channel is an independent circular FIFO with DEPTH entries.
  - Read and write pointers wrap modulo DEPTH.
  - The occupancy count ranges 0..DEPTH.
- x_in_ready = (count < DEPTH). It depends only on registered state, so there is no ready→ready combinational path.
- d_out_valid = (d_count != 0).
- a_out_valid = (a_count != 0) && (inflight < MAX_INFLIGHT).
- x_out_* payload always presents the head entry. Payload is don't-care when x_out_valid is low.
- Enqueue on x_in fire and dequeue on x_out fire. Simultaneous enqueue and dequeue leaves the count unchanged and advances both pointers.
- Full FIFO: in_ready is low even if out fires the same cycle, so there is no enqueue that cycle. Ready rises the next cycle.
- Empty FIFO: no flow-through. An enqueue is visible at the output one cycle later.
- The buffer carries TL-UL only: every D beat is a complete response.
- inflight update rules:
  - +1 on a_out fire.
  - −1 on d_out fire.
  - Unchanged when both fire in the same cycle.
- d_out fire while inflight == 0:
  - inflight stays 0 (saturates).
  - protocol_err sets to 1 and holds until reset.
  - The beat is still passed upstream.
- The buffer does not modify, check or reorder payload. Reordering across source IDs is the slave's responsibility.

## Timing
- Reset values:
  - a_in_ready = 1, d_in_ready = 1.
  - a_out_valid = 0, d_out_valid = 0.
  - inflight = 0, protocol_err = 0.
  - Pointers and counts = 0.
  - Payload registers need no reset.
- Latency: x_in fire at cycle N gives x_out_valid at N+1, provided the FIFO was empty. For A, the inflight cap must also permit it.
- Sustained throughput is 1 beat/cycle per channel when DEPTH ≥ 2 and the consumer is always ready.
- With DEPTH = 1, throughput is 1 beat per 2 cycles.
- When the cap is reached (inflight == MAX_INFLIGHT), a_out_valid drops in the same cycle inflight reaches the cap. It re-asserts the cycle after a d_out fire lowers inflight.
- Once asserted, a_out_valid must not drop without a fire, except through reset or the cap.
- The cap can only change on an a_out fire, so it never withdraws a pending valid.
- Reset asserted mid-transfer immediately deasserts both out_valid outputs and discards all buffered beats. No partial state survives.

## Test plan
- Reset then idle:
  - Required: a_in_ready = d_in_ready = 1, both out_valid = 0, inflight = 0.
- Single Get passthrough:
  - Stimulus: A Get with address 0x0001234, size 2, mask 0xF.
  - Required: a_out matches the next cycle and inflight goes to 1.
  - Stimulus: AccessAckData with data 0xDEADBEEF.
  - Required: d_out matches one cycle later and inflight returns to 0.
- Back-pressure fill:
  - Stimulus: hold a_out_ready = 0 and push 3 beats with DEPTH = 2.
  - Required: a_in_ready drops after 2 accepted beats. On release, the beats drain in order at 1 per cycle, and a_in_ready returns the cycle after the first dequeue.
- Inflight cap:
  - Stimulus: issue 5 Puts with no D responses and MAX_INFLIGHT = 4.
  - Required: exactly 4 fire downstream and a_out_valid stays low on the 5th.
  - Stimulus: one AccessAck.
  - Required: the 5th fires the following cycle.
- Simultaneous fire:
  - Stimulus: a_out fire and d_out fire in the same cycle with inflight = 2.
  - Required: inflight stays 2. A full FIFO with in and out valid does not enqueue that cycle.
- Spurious response and reset:
  - Stimulus: a D beat with inflight = 0.
  - Required: it passes upstream, protocol_err = 1, inflight = 0.
  - Stimulus: reset asserted with 2 beats buffered.
  - Required: valids drop immediately and protocol_err clears.

Source files
------------

// File: rtl/tl_ul_link_buffer.sv
// -----------------------------------------------------------------------------
// tl_ul_link_buffer
//
// Registered TileLink-UL buffer stage for a 26-bit peripheral port. Each
// channel (A downstream, D upstream) passes through its own DEPTH-entry
// circular FIFO. The buffer limits the number of outstanding A requests to
// MAX_INFLIGHT and raises a sticky error when a D beat leaves with nothing
// outstanding. Payloads pass through unmodified and in order.
//
// Ports
//   clock, reset               sole clock; asynchronous active-high reset
//   a_in_*  (valid/ready/..)   A channel from the master
//   a_out_* (valid/ready/..)   A channel to the slave
//   d_in_*  (valid/ready/..)   D channel from the slave
//   d_out_* (valid/ready/..)   D channel to the master
//   inflight [2:0]             A requests issued and not yet answered
//   protocol_err               sticky: a D beat was returned with inflight == 0
// -----------------------------------------------------------------------------

// Circular FIFO with registered occupancy. The caller only pushes when not
// full and only pops when not empty. There is no flow-through: a pushed entry
// becomes visible at head the cycle after the push.
//
// Ports
//   clock, reset     clock and asynchronous active-high reset
//   push, push_data  write one entry at the tail
//   pop              retire the head entry
//   head             current head entry (don't-care while empty)
//   empty, full      occupancy flags, derived from registered state only
module tl_ul_link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = mem[rd_ptr];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

module tl_ul_link_buffer #(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset,
  // A channel, master side
  input  logic        a_in_valid,
  output logic        a_in_ready,
  input  logic [2:0]  a_in_opcode,
  input  logic [2:0]  a_in_param,
  input  logic [1:0]  a_in_size,
  input  logic        a_in_source,
  input  logic [25:0] a_in_address,
  input  logic [3:0]  a_in_mask,
  input  logic [31:0] a_in_data,
  input  logic        a_in_corrupt,
  // A channel, slave side
  output logic        a_out_valid,
  input  logic        a_out_ready,
  output logic [2:0]  a_out_opcode,
  output logic [2:0]  a_out_param,
  output logic [1:0]  a_out_size,
  output logic        a_out_source,
  output logic [25:0] a_out_address,
  output logic [3:0]  a_out_mask,
  output logic [31:0] a_out_data,
  output logic        a_out_corrupt,
  // D channel, slave side
  input  logic        d_in_valid,
  output logic        d_in_ready,
  input  logic [2:0]  d_in_opcode,
  input  logic [1:0]  d_in_param,
  input  logic [1:0]  d_in_size,
  input  logic        d_in_source,
  input  logic        d_in_sink,
  input  logic        d_in_denied,
  input  logic [31:0] d_in_data,
  input  logic        d_in_corrupt,
  // D channel, master side
  output logic        d_out_valid,
  input  logic        d_out_ready,
  output logic [2:0]  d_out_opcode,
  output logic [1:0]  d_out_param,
  output logic [1:0]  d_out_size,
  output logic        d_out_source,
  output logic        d_out_sink,
  output logic        d_out_denied,
  output logic [31:0] d_out_data,
  output logic        d_out_corrupt,
  // Status
  output logic [2:0]  inflight,
  output logic        protocol_err
);

  localparam int A_W = 72;
  localparam int D_W = 43;
  localparam logic [2:0] CAP = 3'(MAX_INFLIGHT);

  logic           a_empty, a_full, a_push, a_pop;
  logic           d_empty, d_full, d_push, d_pop;
  logic [A_W-1:0] a_head;
  logic [D_W-1:0] d_head;

  // Ready comes from registered occupancy only, so a full FIFO refuses a beat
  // even in a cycle where its head is being dequeued.
  assign a_in_ready  = !a_full;
  assign d_in_ready  = !d_full;
  assign a_out_valid = !a_empty && (inflight < CAP);
  assign d_out_valid = !d_empty;

  assign a_push = a_in_valid  && a_in_ready;
  assign a_pop  = a_out_valid && a_out_ready;
  assign d_push = d_in_valid  && d_in_ready;
  assign d_pop  = d_out_valid && d_out_ready;

  tl_ul_link_fifo #(.WIDTH(A_W), .DEPTH(DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (a_push),
    .push_data ({a_in_opcode, a_in_param, a_in_size, a_in_source,
                 a_in_address, a_in_mask, a_in_data, a_in_corrupt}),
    .pop       (a_pop),
    .head      (a_head),
    .empty     (a_empty),
    .full      (a_full)
  );

  tl_ul_link_fifo #(.WIDTH(D_W), .DEPTH(DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (d_push),
    .push_data ({d_in_opcode, d_in_param, d_in_size, d_in_source,
                 d_in_sink, d_in_denied, d_in_data, d_in_corrupt}),
    .pop       (d_pop),
    .head      (d_head),
    .empty     (d_empty),
    .full      (d_full)
  );

  assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
          a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_head;
  assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
          d_out_sink, d_out_denied, d_out_data, d_out_corrupt} = d_head;

  // Outstanding-request tracking. Every TL-UL D beat is a full response, so
  // each D fire retires exactly one request. A D beat with nothing
  // outstanding still passes upstream, but leaves a sticky error behind and
  // does not underflow the counter. The cap only rises on an A fire, so it
  // can never withdraw an A valid that has not fired.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (d_pop && (inflight == '0)) protocol_err <= 1'b1;
      case ({a_pop, d_pop})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= (inflight == '0) ? '0 : inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
